// File: rtl/uart_nios2_gen2_0_cpu_ocimem_arb_pkg.sv
// uart_nios2_gen2_0_cpu_ocimem_arb_pkg: shared types and jdo field positions for the OCI RAM arbiter
package uart_nios2_gen2_0_cpu_ocimem_arb_pkg;
  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
  typedef enum logic {REQ_JTAG, REQ_CPU} req_t;
  localparam int JDO_W = 38;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_RDEN_BIT = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;
endpackage

// File: rtl/uart_nios2_gen2_0_cpu_ocimem_arb.sv
// uart_nios2_gen2_0_cpu_ocimem_arb: shares the OCI debug RAM between JTAG debug commands and the CPU slave
module uart_nios2_gen2_0_cpu_ocimem_arb
  import uart_nios2_gen2_0_cpu_ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);
  state_t state, state_nx;
  req_t rr;
  logic [ADDR_W-1:0] addr_cnt;
  logic j_pend, j_wr, j_inc;
  logic [31:0] j_wdata;
  logic idle, c_req, j_gnt, c_gnt;
  logic [1:0] n_stb;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};
  // reset_n gates the grant so waitrequest reads 1 throughout reset
  assign idle = state == IDLE && reset_n;
  assign c_req = avs_read | avs_write;
  assign j_gnt = idle && j_pend && (!c_req || rr == REQ_JTAG);
  assign c_gnt = idle && c_req && (!j_pend || rr == REQ_CPU);
  assign avs_waitrequest = !c_gnt;
  assign monitor_ready = reset_n && !j_pend && state != J_RD;
  assign n_stb = 2'(take_action_ocimem_a) + 2'(take_action_ocimem_b) + 2'(take_no_action_ocimem_a);
  always_comb begin
    state_nx = state != IDLE ? IDLE :
               (j_gnt && !j_wr) ? J_RD :
               (c_gnt && avs_read) ? C_RD : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr <= REQ_JTAG;
      addr_cnt <= '0;
      j_pend <= 1'b0;
      j_wr <= 1'b0;
      j_inc <= 1'b0;
      j_wdata <= '0;
      jtag_overrun <= 1'b0;
      ram_addr <= '0;
      ram_wren <= 1'b0;
      ram_byteen <= '0;
      ram_wdata <= '0;
      MonDReg <= '0;
      avs_readdata <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      state <= state_nx;
      ram_wren <= 1'b0;
      avs_readdatavalid <= 1'b0;
      if (n_stb != 2'd0 && (j_pend || n_stb > 2'd1)) jtag_overrun <= 1'b1;
      // pending covers the J_RD cycle too, so in-flight reads also drop strobes
      if (!j_pend) begin
        if (take_action_ocimem_b) begin
          j_pend <= 1'b1;
          j_wr <= 1'b1;
          j_inc <= 1'b1;
          j_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end else if (take_action_ocimem_a) begin
          addr_cnt <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
          j_pend <= jdo[JDO_RDEN_BIT];
          j_wr <= 1'b0;
          j_inc <= 1'b0;
        end else if (take_no_action_ocimem_a) begin
          j_pend <= 1'b1;
          j_wr <= 1'b0;
          j_inc <= 1'b1;
        end
      end
      if (j_gnt) begin
        rr <= REQ_CPU;
        ram_addr <= addr_cnt;
        ram_wren <= j_wr;
        ram_byteen <= 4'hF;
        ram_wdata <= j_wdata;
        if (j_inc) addr_cnt <= addr_cnt + 1'b1;
        if (j_wr) j_pend <= 1'b0;
      end
      if (c_gnt) begin
        rr <= REQ_JTAG;
        ram_addr <= avs_address;
        ram_wren <= avs_write;
        ram_byteen <= avs_byteenable;
        ram_wdata <= avs_writedata;
      end
      if (state == J_RD) begin
        MonDReg <= ram_rdata;
        j_pend <= 1'b0;
      end
      if (state == C_RD) begin
        avs_readdata <= ram_rdata;
        avs_readdatavalid <= 1'b1;
      end
    end
  end
endmodule
